tarot_draw_ctrl: RTL and testbench

TAROT_DRAW_CTRL -- requirements
Module: tarot_draw_ctrl

---
 rtl/tarot_draw_ctrl_if.sv | 35 +++
 rtl/tarot_draw_ctrl.sv | 167 ++++++++++++++++
 tb/tb_tarot_draw_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tarot_draw_ctrl_if.sv
// Host request, PRNG handshake and card-output signals of the tarot draw controller.
interface tarot_draw_ctrl_if;
   logic        req;
   logic [3:0]  spread_len;
   logic [31:0] seed_q31;
   logic [31:0] fingerprint_mean;
   logic        busy;
   logic        prng_start;
   logic [31:0] prng_seed;
   logic [31:0] prng_mean;
   logic [31:0] prng_x;
   logic [31:0] prng_y;
   logic        prng_done;
   logic        card_valid;
   logic        card_ready;
   logic [6:0]  card_idx;
   logic        card_reversed;
   logic        card_last;
   logic        draw_done;
   logic        error;

   modport master (
      output req, spread_len, seed_q31, fingerprint_mean,
      output prng_x, prng_y, prng_done, card_ready,
      input  busy, prng_start, prng_seed, prng_mean,
      input  card_valid, card_idx, card_reversed, card_last, draw_done, error
   );

   modport slave (
      input  req, spread_len, seed_q31, fingerprint_mean,
      input  prng_x, prng_y, prng_done, card_ready,
      output busy, prng_start, prng_seed, prng_mean,
      output card_valid, card_idx, card_reversed, card_last, draw_done, error
   );
endinterface

// File: rtl/tarot_draw_ctrl.sv
// Draws spread_len distinct tarot cards by polling an external PRNG, rejecting
// out-of-range and repeated indices, and streaming accepted cards out.
module tarot_draw_ctrl #(
   parameter int unsigned NUM_CARDS  = 78,
   parameter int unsigned MAX_SPREAD = 10,
   parameter int unsigned MAX_RETRY  = 16
) (
   input logic              clk,
   input logic              rst,
   tarot_draw_ctrl_if.slave bus
);
   localparam int unsigned CARD_W  = 7;
   localparam int unsigned LEN_W   = 4;
   localparam int unsigned ATT_W   = 8;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

   typedef enum logic [2:0] {IDLE, REQ, RELEASE, EVAL, OUT, FINISH} state_t;

   state_t               state, state_n;
   logic [LEN_W-1:0]     len_q;
   logic [LEN_W-1:0]     card_cnt_q;
   logic [RETRY_W-1:0]   retry_q;
   logic [ATT_W-1:0]     att_q;
   logic [NUM_CARDS-1:0] used_q;
   logic [CARD_W-1:0]    cand_q;
   logic                 rev_q;

   logic                 accept_c, capture_c, take_c, reject_c, abort_c, handshake_c;
   logic                 bad_len_c, cand_ok_c, last_c, retry_full_c;
   logic [NUM_CARDS-1:0] cand_mask_c;
   logic [RETRY_W-1:0]   retry_inc_c;
   logic [ATT_W-1:0]     att_inc_c;
   logic                 unused_ok;

   // Only the sign bit of prng_y carries information for this block.
   assign unused_ok = ^bus.prng_y[30:0];

   // Candidate qualification and counter arithmetic
   always_comb begin
      bad_len_c    = (bus.spread_len == '0) || (WORD_W'(bus.spread_len) > MAX_SPREAD);
      cand_mask_c  = NUM_CARDS'(1) << cand_q;
      cand_ok_c    = (WORD_W'(cand_q) < NUM_CARDS) && ((used_q & cand_mask_c) == '0);
      retry_inc_c  = RETRY_W'(retry_q + RETRY_W'(1));
      retry_full_c = (WORD_W'(retry_inc_c) == MAX_RETRY);
      att_inc_c    = ATT_W'(att_q + ATT_W'(1));
      last_c       = (LEN_W'(card_cnt_q + LEN_W'(1)) == len_q);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state and transaction strobes
   always_comb begin
      state_n     = state;
      accept_c    = 1'b0;
      capture_c   = 1'b0;
      take_c      = 1'b0;
      reject_c    = 1'b0;
      abort_c     = 1'b0;
      handshake_c = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req) begin
               accept_c = 1'b1;
               if (bad_len_c) begin
                  abort_c = 1'b1;
                  state_n = FINISH;
               end else begin
                  state_n = REQ;
               end
            end
         end
         REQ: begin
            if (bus.prng_done) begin
               capture_c = 1'b1;
               state_n   = RELEASE;
            end
         end
         RELEASE: begin
            if (!bus.prng_done) state_n = EVAL;
         end
         EVAL: begin
            if (cand_ok_c) begin
               take_c  = 1'b1;
               state_n = OUT;
            end else begin
               reject_c = 1'b1;
               if (retry_full_c) begin
                  abort_c = 1'b1;
                  state_n = FINISH;
               end else begin
                  state_n = REQ;
               end
            end
         end
         OUT: begin
            if (bus.card_ready) begin
               handshake_c = 1'b1;
               state_n     = bus.card_last ? FINISH : REQ;
            end
         end
         FINISH:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath and registered outputs; status flags follow the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q             <= '0;
         card_cnt_q        <= '0;
         retry_q           <= '0;
         att_q             <= '0;
         used_q            <= '0;
         cand_q            <= '0;
         rev_q             <= 1'b0;
         bus.busy          <= 1'b0;
         bus.prng_start    <= 1'b0;
         bus.prng_seed     <= '0;
         bus.prng_mean     <= '0;
         bus.card_valid    <= 1'b0;
         bus.card_idx      <= '0;
         bus.card_reversed <= 1'b0;
         bus.card_last     <= 1'b0;
         bus.draw_done     <= 1'b0;
         bus.error         <= 1'b0;
      end else begin
         bus.busy       <= (state_n != IDLE);
         bus.prng_start <= (state_n == REQ);
         bus.card_valid <= (state_n == OUT);
         bus.draw_done  <= (state_n == FINISH);
         bus.error      <= abort_c;

         if (accept_c) begin
            len_q         <= bus.spread_len;
            bus.prng_seed <= bus.seed_q31;
            bus.prng_mean <= bus.fingerprint_mean;
            used_q        <= '0;
            card_cnt_q    <= '0;
            retry_q       <= '0;
            att_q         <= '0;
         end

         // Later attempts reseed from the previous result mixed with the attempt number.
         if (capture_c) begin
            att_q         <= att_inc_c;
            cand_q        <= bus.prng_x[30:24];
            rev_q         <= bus.prng_y[31];
            bus.prng_seed <= bus.prng_x ^ WORD_W'(att_inc_c);
         end

         if (take_c) begin
            used_q            <= used_q | cand_mask_c;
            retry_q           <= '0;
            bus.card_idx      <= cand_q;
            bus.card_reversed <= rev_q;
            bus.card_last     <= last_c;
         end

         if (reject_c)    retry_q    <= retry_inc_c;
         if (handshake_c) card_cnt_q <= LEN_W'(card_cnt_q + LEN_W'(1));
      end
   end
endmodule

// File: tb/tb_tarot_draw_ctrl.sv
// Self-checking bench for tarot_draw_ctrl: PRNG stub fed from response tables,
// card sink with selectable back-pressure, and a rule-level draw model.
module tb_tarot_draw_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tarot_draw_ctrl_if bus ();

   tarot_draw_ctrl #(.NUM_CARDS(78), .MAX_SPREAD(10), .MAX_RETRY(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [6:0] idx;
      logic       rev;
      logic       last;
   } card_t;

   int checks = 0;
   int errors = 0;

   logic [31:0] rx [512];
   logic [31:0] ry [512];
   int          stub_k = 0;
   int          stub_lat = 0;
   bit          stub_lat_rand = 1'b1;
   int          wait_cnt = 0;
   logic        start_d = 1'b0;
   int          n_starts = 0;
   logic [31:0] seed_log [$];

   int    ready_mode = 1;
   int    hold_cnt = 0;
   card_t got [$];
   int    n_done = 0;
   int    n_err = 0;
   bit    prev_pending = 1'b0;
   card_t prev_card;

   logic [7:0]  exp_cards [$];
   logic [31:0] exp_seeds [$];
   int          exp_err;
   int          exp_starts;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: replay the response table through the draw rules.
   task automatic run_model(input int len, input logic [31:0] seed);
      bit          used [128];
      int          retry, att, k, taken, c;
      logic [31:0] cur_seed, x;
      exp_cards.delete();
      exp_seeds.delete();
      exp_err = 0;
      exp_starts = 0;
      foreach (used[i]) used[i] = 1'b0;
      if (len == 0 || len > 10) begin
         exp_err = 1;
         return;
      end
      retry = 0; att = 0; k = 0; taken = 0;
      cur_seed = seed;
      while (taken < len) begin
         exp_seeds.push_back(cur_seed);
         exp_starts++;
         x = rx[k];
         att = (att + 1) % 256;
         cur_seed = x ^ 32'(att);
         c = int'(x[30:24]);
         if (c < 78 && !used[c]) begin
            used[c] = 1'b1;
            retry = 0;
            exp_cards.push_back({ry[k][31], 7'(c)});
            taken++;
         end else begin
            retry++;
            if (retry == 16) begin
               exp_err = 1;
               break;
            end
         end
         k++;
      end
   endtask

   // PRNG stub: answers each start after a latency, holds done until start drops.
   always @(negedge clk) begin
      if (bus.prng_start && !start_d) begin
         n_starts++;
         seed_log.push_back(bus.prng_seed);
         check("start_while_done", 32'(bus.prng_done), 32'd0);
         wait_cnt = stub_lat_rand ? $urandom_range(0, 2) : stub_lat;
      end
      start_d = bus.prng_start;
      if (bus.prng_start && !bus.prng_done) begin
         if (wait_cnt == 0) begin
            bus.prng_done = 1'b1;
            bus.prng_x    = rx[stub_k];
            bus.prng_y    = ry[stub_k];
            stub_k        = (stub_k + 1) % 512;
         end else begin
            wait_cnt--;
         end
      end else if (!bus.prng_start && bus.prng_done) begin
         bus.prng_done = 1'b0;
         bus.prng_x    = $urandom;
         bus.prng_y    = $urandom;
      end
   end

   // Card sink and pulse monitor
   always @(negedge clk) begin
      if (prev_pending) begin
         check("hold_valid", 32'(bus.card_valid), 32'd1);
         check("hold_idx", 32'(bus.card_idx), 32'(prev_card.idx));
         check("hold_rev", 32'(bus.card_reversed), 32'(prev_card.rev));
         check("hold_last", 32'(bus.card_last), 32'(prev_card.last));
         check("hold_no_start", 32'(bus.prng_start), 32'd0);
      end
      case (ready_mode)
         0: bus.card_ready = 1'($urandom_range(0, 1));
         2: begin
            if (bus.card_valid && hold_cnt < 5) begin
               bus.card_ready = 1'b0;
               hold_cnt++;
            end else begin
               bus.card_ready = 1'b1;
            end
         end
         default: bus.card_ready = 1'b1;
      endcase
      if (bus.card_valid && bus.card_ready)
         got.push_back('{idx: bus.card_idx, rev: bus.card_reversed, last: bus.card_last});
      prev_pending   = bus.card_valid && !bus.card_ready;
      prev_card.idx  = bus.card_idx;
      prev_card.rev  = bus.card_reversed;
      prev_card.last = bus.card_last;
      if (bus.draw_done) n_done++;
      if (bus.error) begin
         n_err++;
         check("error_with_done", 32'(bus.draw_done), 32'd1);
      end
   end

   task automatic do_draw(input logic [3:0] len, input logic [31:0] seed, input logic [31:0] mean,
                          input string tag);
      int cyc;
      bit bad;
      bad = (len == 0 || len > 10);
      run_model(int'(len), seed);
      @(negedge clk);
      got.delete();
      seed_log.delete();
      n_starts = 0; n_done = 0; n_err = 0; stub_k = 0;
      bus.req = 1'b1;
      bus.spread_len = len;
      bus.seed_q31 = seed;
      bus.fingerprint_mean = mean;
      @(negedge clk);
      bus.req = 1'b0;
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_mean"}, bus.prng_mean, mean);
      if (bad) check({tag, "_early_done"}, 32'(bus.draw_done), 32'd1);
      // Inputs and stray requests while busy must not disturb the draw.
      bus.spread_len = 4'($urandom);
      bus.seed_q31 = $urandom;
      bus.fingerprint_mean = $urandom;
      cyc = 0;
      while (n_done == 0 && cyc < 4000) begin
         bus.req = (bus.busy && !bus.draw_done) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         cyc++;
      end
      bus.req = 1'b0;
      if (cyc >= 4000) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
      end
      repeat (2) @(negedge clk);
      check({tag, "_mean_held"}, bus.prng_mean, mean);
      check({tag, "_done_cnt"}, 32'(n_done), 32'd1);
      check({tag, "_err_cnt"}, 32'(n_err), 32'(exp_err));
      check({tag, "_starts"}, 32'(n_starts), 32'(exp_starts));
      check({tag, "_ncards"}, 32'(got.size()), 32'(exp_cards.size()));
      for (int i = 0; i < got.size() && i < exp_cards.size(); i++) begin
         check({tag, "_idx"}, 32'(got[i].idx), 32'(exp_cards[i][6:0]));
         check({tag, "_rev"}, 32'(got[i].rev), 32'(exp_cards[i][7]));
         check({tag, "_last"}, 32'(got[i].last), 32'(i + 1 == int'(len)));
      end
      for (int i = 0; i < seed_log.size() && i < exp_seeds.size(); i++)
         check({tag, "_seed"}, seed_log[i], exp_seeds[i]);
   endtask

   task automatic fill_tables(input logic [31:0] x, input logic [31:0] y);
      for (int i = 0; i < 512; i++) begin
         rx[i] = x;
         ry[i] = y;
      end
   endtask

   initial begin
      int cyc;
      bus.req = 1'b0;
      bus.spread_len = '0;
      bus.seed_q31 = '0;
      bus.fingerprint_mean = '0;
      bus.prng_done = 1'b0;
      bus.prng_x = '0;
      bus.prng_y = '0;
      bus.card_ready = 1'b0;
      fill_tables(32'h0500_0000, 32'h0);

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_prng_start", 32'(bus.prng_start), 32'd0);
      check("rst_card_valid", 32'(bus.card_valid), 32'd0);
      check("rst_card_last", 32'(bus.card_last), 32'd0);
      check("rst_card_rev", 32'(bus.card_reversed), 32'd0);
      check("rst_draw_done", 32'(bus.draw_done), 32'd0);
      check("rst_error", 32'(bus.error), 32'd0);
      check("rst_card_idx", 32'(bus.card_idx), 32'd0);
      check("rst_prng_seed", bus.prng_seed, 32'd0);
      check("rst_prng_mean", bus.prng_mean, 32'd0);
      rst = 1'b0;

      // Three-card spread with one repeat rejection
      fill_tables(32'h0500_0000, 32'h0);
      rx[0] = 32'h0500_0000; ry[0] = 32'h8000_0000;
      rx[1] = 32'h0500_0000; ry[1] = 32'h0;
      rx[2] = 32'h1000_0000; ry[2] = 32'h0;
      rx[3] = 32'h4D00_0000; ry[3] = 32'h0;
      do_draw(4'd3, 32'h1234_5678, 32'hCAFE_F00D, "spread3");

      // Out-of-range indices 78 and 127 rejected
      rx[0] = 32'h4E00_0000;
      rx[1] = 32'h7F00_0000;
      rx[2] = 32'h0000_0000;
      do_draw(4'd1, 32'hA5A5_0001, 32'h4000_0000, "range");

      // Retry exhaustion after one good card
      fill_tables(32'h0500_0000, 32'h0);
      do_draw(4'd2, 32'h0BAD_BEEF, 32'h1111_1111, "retry");

      // Back-pressure for five cycles
      ready_mode = 2;
      hold_cnt = 0;
      rx[0] = 32'h2A00_0000; ry[0] = 32'h8000_0000;
      do_draw(4'd1, 32'h7777_0000, 32'h2222_2222, "backpr");
      check("backpr_held5", 32'(hold_cnt), 32'd5);
      ready_mode = 1;

      // Illegal spread lengths
      do_draw(4'd0, 32'h1, 32'h2, "len0");
      do_draw(4'd11, 32'h3, 32'h4, "len11");

      // Reset while waiting on the PRNG
      stub_lat_rand = 1'b0;
      stub_lat = 50;
      @(negedge clk);
      bus.req = 1'b1;
      bus.spread_len = 4'd2;
      bus.seed_q31 = 32'h5555_5555;
      @(negedge clk);
      bus.req = 1'b0;
      cyc = 0;
      while (!bus.prng_start && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("mid_rst_in_req", 32'(bus.prng_start), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_start_low", 32'(bus.prng_start), 32'd0);
      check("mid_rst_busy_low", 32'(bus.busy), 32'd0);
      stub_lat_rand = 1'b1;
      @(negedge clk);
      rx[0] = 32'h0500_0000; ry[0] = 32'h0;
      do_draw(4'd1, 32'h6666_0000, 32'h3333_3333, "post_rst");

      // Randomized draws with random back-pressure
      ready_mode = 0;
      for (int t = 0; t < 25; t++) begin
         logic [3:0] len;
         for (int i = 0; i < 512; i++) begin
            rx[i] = $urandom;
            ry[i] = $urandom;
         end
         len = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(1, 10));
         do_draw(len, $urandom, $urandom, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: observed no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
